// File: rtl/jtag_scan_master.sv
// JTAG scan master. It drives TMS/TDI into a target TAP and captures TDO.
// It runs reset sequences, IR scans and DR scans.
// The FSM state always equals the target TAP state (the RESET_SEQ phase covers
// Test-Logic-Reset). TMS and TDI are launched on falling TCK from the value that
// the next rising edge needs, which gives the target half a cycle of setup.
module jtag_scan_master #(
    parameter int IR_REG_WIDTH = 5,
    parameter int DR_REG_WIDTH = 32,
    parameter int LEN_WIDTH    = 6
) (
    input  logic                    TCK,
    input  logic                    TRSTB,
    input  logic                    START,
    input  logic                    SCAN_IR,
    input  logic [LEN_WIDTH-1:0]    LEN,
    input  logic [DR_REG_WIDTH-1:0] DIN,
    input  logic                    RST_REQ,
    output logic                    BUSY,
    output logic                    DONE,
    output logic [DR_REG_WIDTH-1:0] DOUT,
    output logic                    TMS,
    output logic                    TDI,
    input  logic                    TDO
);

    typedef enum logic [2:0] {
        RESET_SEQ, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE
    } state_t;

    localparam logic [LEN_WIDTH-1:0] DR_MAX   = LEN_WIDTH'(DR_REG_WIDTH);
    localparam logic [LEN_WIDTH-1:0] IR_LEN   = LEN_WIDTH'(IR_REG_WIDTH);
    localparam logic [LEN_WIDTH-1:0] RST_ONES = LEN_WIDTH'(5);

    state_t                  state_q, state_d;
    logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;     // reset-sequence edge count / shift bit index
    logic [LEN_WIDTH-1:0]    len_q, len_d;     // effective bit count of the current scan
    logic                    ir_q, ir_d;
    logic [DR_REG_WIDTH-1:0] din_q, din_d;
    logic [DR_REG_WIDTH-1:0] dout_q, dout_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    tms_q, tms_d;
    logic                    tdi_q, tdi_d;

    // Next-state logic, plus the TMS/TDI values the next rising edge will sample
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ir_d    = ir_q;
        din_d   = din_q;
        dout_d  = dout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        tms_d   = 1'b0;
        tdi_d   = 1'b0;
        case (state_q)
            RESET_SEQ: begin
                // Five ones walk any TAP state into Test-Logic-Reset, then a zero lands it in Run-Test/Idle
                tms_d = (cnt_q < RST_ONES);
                if (cnt_q == RST_ONES) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + LEN_WIDTH'(1);
                end
            end
            IDLE: begin
                if (busy_q) begin
                    // A scan was accepted on the previous edge. A zero-length DR scan finishes here without touching TMS
                    if (len_q == '0) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        tms_d   = 1'b1;
                        state_d = SEL_DR;
                    end
                end else if (START) begin
                    ir_d   = SCAN_IR;
                    len_d  = SCAN_IR ? IR_LEN : ((LEN > DR_MAX) ? DR_MAX : LEN);
                    din_d  = DIN;
                    dout_d = '0;
                    busy_d = 1'b1;
                    cnt_d  = '0;
                end else if (RST_REQ) begin
                    state_d = RESET_SEQ;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            SEL_DR: begin
                tms_d   = ir_q;
                state_d = ir_q ? SEL_IR : CAPTURE;
            end
            SEL_IR: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                state_d = SHIFT;
                cnt_d   = '0;
            end
            SHIFT: begin
                for (int i = 0; i < DR_REG_WIDTH; i++) begin
                    if (cnt_q == LEN_WIDTH'(i)) begin
                        tdi_d     = din_q[i];
                        dout_d[i] = TDO;
                    end
                end
                tms_d = (cnt_q == len_q - LEN_WIDTH'(1));
                if (tms_d) begin
                    state_d = EXIT1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + LEN_WIDTH'(1);
                end
            end
            EXIT1: begin
                tms_d   = 1'b1;
                state_d = UPDATE;
            end
            UPDATE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = RESET_SEQ;
        endcase
    end

    // FSM, counters and TDO capture advance on rising TCK
    always_ff @(posedge TCK or negedge TRSTB) begin
        if (!TRSTB) begin
            state_q <= RESET_SEQ;
            cnt_q   <= '0;
            len_q   <= '0;
            ir_q    <= 1'b0;
            din_q   <= '0;
            dout_q  <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ir_q    <= ir_d;
            din_q   <= din_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Target-facing pins launch on falling TCK
    always_ff @(negedge TCK or negedge TRSTB) begin
        if (!TRSTB) begin
            tms_q <= 1'b1;
            tdi_q <= 1'b0;
        end else begin
            tms_q <= tms_d;
            tdi_q <= tdi_d;
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign DOUT = dout_q;
    assign TMS  = tms_q;
    assign TDI  = tdi_q;

endmodule
